// File: rtl/retro_bram_banked.sv
// Multi-bank single-port block RAM with byte lanes, 1/2-cycle read latency
// and an optional zero-fill sweep after reset.
module retro_bram_banked #(
    parameter int AddressBusWidth  = 16,
    parameter int DataBusWidth     = 8,
    parameter int BankAddressWidth = 12,
    parameter int ReadLatency      = 1,
    parameter int ClearOnReset     = 1
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Access,
    input  logic                          Write,
    input  logic [AddressBusWidth-1:0]    Address,
    input  logic [DataBusWidth/8-1:0]     ByteEnable,
    input  logic [DataBusWidth-1:0]       DataIn,
    output logic                          Ready,
    output logic [DataBusWidth-1:0]       DataOut,
    output logic                          DataReady,
    output logic                          Busy
);
    localparam int Banks = 1 << (AddressBusWidth - BankAddressWidth);
    localparam int Depth = 1 << BankAddressWidth;
    localparam int Lanes = DataBusWidth / 8;
    localparam int SelW  = (AddressBusWidth > BankAddressWidth) ?
                           (AddressBusWidth - BankAddressWidth) : 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]                  state;
    logic [BankAddressWidth-1:0] clear_count;
    logic [SelW-1:0]             bank;
    logic [SelW-1:0]             bank_q;
    logic [BankAddressWidth-1:0] index;
    logic                        accept;
    logic                        wr;
    logic                        rd;
    logic                        rd_v1;
    logic [DataBusWidth-1:0]     rd_word;

    assign index = Address[BankAddressWidth-1:0];

    if (AddressBusWidth > BankAddressWidth) begin : g_bank_sel
        assign bank = Address[AddressBusWidth-1:BankAddressWidth];
    end else begin : g_one_bank
        assign bank = '0;
    end

    // Outputs are forced low while reset is held, independent of FSM state
    assign Busy   = Reset_n & (state == ST_CLEAR);
    assign Ready  = Reset_n & (state == ST_RUN);
    assign accept = Access & Ready;
    assign wr     = accept & Write;
    assign rd     = accept & ~Write;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= (ClearOnReset != 0) ? ST_CLEAR : ST_RUN;
            clear_count <= '0;
        end else if (state == ST_CLEAR) begin
            clear_count <= clear_count + 1'b1;
            if (&clear_count) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_v1  <= 1'b0;
            bank_q <= '0;
        end else begin
            rd_v1 <= rd;
            if (rd) begin
                bank_q <= bank;
            end
        end
    end

    // One byte-wide array per lane; a row holds that lane for every bank,
    // so the sweep clears all banks at one index in a single write.
    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        logic [Banks-1:0][7:0] mem [Depth];
        logic [Banks-1:0][7:0] row_q;

        always_ff @(posedge Clk) begin
            if (Busy) begin
                mem[clear_count] <= '0;
            end else if (wr && ByteEnable[l]) begin
                mem[index][bank] <= DataIn[8*l +: 8];
            end
            if (rd) begin
                row_q <= mem[index];
            end
        end

        assign rd_word[8*l +: 8] = row_q[bank_q];
    end

    if (ReadLatency == 2) begin : g_rl2
        logic                    rd_v2;
        logic [DataBusWidth-1:0] dout_q;

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                rd_v2  <= 1'b0;
                dout_q <= '0;
            end else begin
                rd_v2 <= rd_v1;
                if (rd_v1) begin
                    dout_q <= rd_word;
                end
            end
        end

        assign DataReady = rd_v2;
        assign DataOut   = dout_q;
    end else begin : g_rl1
        // row_q/bank_q only move on reads, so the mux output already holds
        logic have_q;

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                have_q <= 1'b0;
            end else if (rd) begin
                have_q <= 1'b1;
            end
        end

        assign DataReady = rd_v1;
        assign DataOut   = have_q ? rd_word : '0;
    end

endmodule

// File: tb/tb_retro_bram_banked.sv
// Directed bench: 32-bit/BAW4/RL2 instance (a) and 8-bit/BAW12/RL1
// instance (b) share one request bus.
module tb_retro_bram_banked;

    logic        clk;
    logic        rst_n;
    logic        acc;
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] din;

    logic        a_ready;
    logic [31:0] a_dout;
    logic        a_dr;
    logic        a_busy;
    logic        b_ready;
    logic [7:0]  b_dout;
    logic        b_dr;
    logic        b_busy;

    int passed = 0;
    int total  = 0;

    retro_bram_banked #(
        .AddressBusWidth(16),
        .DataBusWidth(32),
        .BankAddressWidth(4),
        .ReadLatency(2),
        .ClearOnReset(1)
    ) u_a (
        .Clk(clk),
        .Reset_n(rst_n),
        .Access(acc),
        .Write(wr),
        .Address(addr),
        .ByteEnable(be),
        .DataIn(din),
        .Ready(a_ready),
        .DataOut(a_dout),
        .DataReady(a_dr),
        .Busy(a_busy)
    );

    retro_bram_banked #(
        .AddressBusWidth(16),
        .DataBusWidth(8),
        .BankAddressWidth(12),
        .ReadLatency(1),
        .ClearOnReset(1)
    ) u_b (
        .Clk(clk),
        .Reset_n(rst_n),
        .Access(acc),
        .Write(wr),
        .Address(addr),
        .ByteEnable(be[0]),
        .DataIn(din[7:0]),
        .Ready(b_ready),
        .DataOut(b_dout),
        .DataReady(b_dr),
        .Busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wr_req(input logic [15:0] a, input logic [3:0] be_i,
                          input logic [31:0] d);
        @(negedge clk);
        acc  = 1'b1;
        wr   = 1'b1;
        addr = a;
        be   = be_i;
        din  = d;
        @(posedge clk);
        #1;
        acc = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic rd_chk(input logic [15:0] a, input logic [31:0] ea,
                          input logic [7:0] eb, input string tag);
        logic [2:0]  pa;
        logic [2:0]  pb;
        logic [31:0] da;
        logic [7:0]  db;
        pa = '0;
        pb = '0;
        da = '0;
        db = '0;
        @(negedge clk);
        acc  = 1'b1;
        wr   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        acc = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            pa[j] = a_dr;
            pb[j] = b_dr;
            if (a_dr) da = a_dout;
            if (b_dr) db = b_dout;
        end
        chk({tag, "_a_lat"}, 32'(pa), 32'b010);
        chk({tag, "_a_data"}, da, ea);
        chk({tag, "_b_lat"}, 32'(pb), 32'b001);
        chk({tag, "_b_data"}, 32'(db), 32'(eb));
    endtask

    initial begin
        int         n;
        logic       bad;
        logic [5:0] pa6;
        logic [5:0] pb6;
        logic [31:0] ad [7];
        logic [7:0]  bd [7];

        rst_n = 1'b0;
        acc   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        be    = '0;
        din   = '0;

        #22;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_dr", 32'(a_dr), 32'd0);
        chk("rst_a_dout", a_dout, 32'd0);
        chk("rst_b_dout", 32'(b_dout), 32'd0);

        // sweep length of the 16-deep instance
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n   = 0;
        bad = 1'b0;
        while (a_busy === 1'b1 && n < 100) begin
            n++;
            if (a_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
            #1;
        end
        chk("a_clear_cycles", n, 32'd16);
        chk("a_ready_while_busy", 32'(bad), 32'd0);
        chk("a_ready_after_clear", 32'(a_ready), 32'd1);
        chk("b_still_busy", 32'(b_busy), 32'd1);

        n = 0;
        while (b_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("b_clear_done", 32'(b_ready), 32'd1);

        rd_chk(16'h0000, 32'h0, 8'h00, "clr0000");
        rd_chk(16'h0010, 32'h0, 8'h00, "clr0010");
        rd_chk(16'hFFFF, 32'h0, 8'h00, "clrFFFF");

        // byte-lane merge
        wr_req(16'h0123, 4'b1111, 32'h11223344);
        wr_req(16'h0123, 4'b0101, 32'hAABBCCDD);
        rd_chk(16'h0123, 32'h11BB33DD, 8'hDD, "be_merge");
        repeat (2) @(negedge clk);
        chk("a_hold", a_dout, 32'h11BB33DD);
        chk("b_hold", 32'(b_dout), 32'h000000DD);

        // back-to-back reads
        for (int i = 0; i < 4; i++) begin
            wr_req(16'h0200 + 16'(i), 4'b1111, 32'hC0DE0000 | 32'(i));
        end
        pa6 = '0;
        pb6 = '0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j > 0) begin
                pa6[j-1] = a_dr;
                pb6[j-1] = b_dr;
                ad[j]    = a_dout;
                bd[j]    = b_dout;
            end
            if (j < 4) begin
                acc  = 1'b1;
                wr   = 1'b0;
                addr = 16'h0200 + 16'(j);
            end else begin
                acc = 1'b0;
            end
        end
        chk("b2b_a_pulses", 32'(pa6), 32'b011110);
        chk("b2b_b_pulses", 32'(pb6), 32'b001111);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_a_data", ad[2+i], 32'hC0DE0000 | 32'(i));
            chk("b2b_b_data", 32'(bd[1+i]), 32'(i));
        end

        // read immediately after write, then a no-op write
        wr_req(16'h0200, 4'b1111, 32'h0000005A);
        rd_chk(16'h0200, 32'h0000005A, 8'h5A, "raw");
        wr_req(16'h0200, 4'b0000, 32'hFFFFFFFF);
        rd_chk(16'h0200, 32'h0000005A, 8'h5A, "be_zero");

        // bank boundary
        wr_req(16'h0FFF, 4'b1111, 32'h000000A1);
        wr_req(16'h1000, 4'b1111, 32'h000000B2);
        rd_chk(16'h0FFF, 32'h000000A1, 8'hA1, "bank_lo");
        rd_chk(16'h1000, 32'h000000B2, 8'hB2, "bank_hi");

        // reset lands on an in-flight read
        @(negedge clk);
        acc  = 1'b1;
        wr   = 1'b0;
        addr = 16'h0200;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        acc   = 1'b0;
        bad   = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (a_dr !== 1'b0 || b_dr !== 1'b0) bad = 1'b1;
        end
        chk("mid_rst_no_dr", 32'(bad), 32'd0);
        chk("mid_rst_a_dout", a_dout, 32'd0);
        chk("mid_rst_b_dout", 32'(b_dout), 32'd0);
        chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
        chk("mid_rst_b_ready", 32'(b_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reclear_a_busy", 32'(a_busy), 32'd1);
        chk("reclear_b_busy", 32'(b_busy), 32'd1);
        n = 0;
        while ((a_ready !== 1'b1 || b_ready !== 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reclear_done", 32'(a_ready & b_ready), 32'd1);
        rd_chk(16'h0200, 32'h0, 8'h00, "reclear_data");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
